// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and periodic modes, state updates on the falling clock edge.
// Periodic reload at terminal count is compiled in only when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             periodic;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    assign periodic = auto_reload;
`else
    logic unused_auto_reload;
    assign unused_auto_reload = auto_reload;
    assign periodic           = 1'b0;
`endif

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Priority: load, then start (not while running), then counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            reload_d = load_val;
            cnt_d    = load_val;
            state_d  = (start && (load_val != ZERO)) ? RUN : IDLE;
        end else if (start && (state_q == IDLE)) begin
            state_d = (cnt_q != ZERO) ? RUN : DONE;
        end else if (start && (state_q == DONE)) begin
            cnt_d   = reload_q;
            state_d = (reload_q != ZERO) ? RUN : DONE;
        end else if ((state_q == RUN) && en) begin
            if (cnt_q > ONE) begin
                cnt_d = cnt_q - ONE;
            end else if (cnt_q == ONE) begin
                // Intercept at 1 so the counter never underflows and periodic mode skips 0.
                tc_d = 1'b1;
                if (periodic && (reload_q != ZERO)) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d   = ZERO;
                    state_d = DONE;
                end
            end else begin
                state_d = DONE;
            end
        end
    end

    assign q    = cnt_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table plus hand-written multi-cycle sequences.
// Expectations for periodic mode follow DOWN_COUNTER_AUTO_RELOAD_EN.
module tb_down_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       en;
    logic       auto_reload;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       tc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       e;
        logic [6:0] ex;   // {q, busy, done, tc}
    } vec_t;

    typedef struct {
        logic [6:0] v;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    down_counter #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] E(input logic [3:0] qq, input logic b, input logic d, input logic t);
        return {qq, b, d, t};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got q=%0d busy=%b done=%b tc=%b, required q=%0d busy=%b done=%b tc=%b",
                     name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic ld, input logic [3:0] lv, input logic st, input logic e, input logic [6:0] ex);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.e = e; v.ex = ex;
        vecs.push_back(v);
    endtask

    // Drive inputs away from the active (falling) edge, compare shortly after it.
    task automatic drive(input string name, input logic ld, input logic [3:0] lv, input logic st,
                         input logic e, input logic ar, input logic [6:0] ex);
        exp_t it;
        @(posedge clk);
        load = ld; load_val = lv; start = st; en = e; auto_reload = ar;
        it.v = ex; it.name = name;
        sb.push_back(it);
        @(negedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, got 0 entries, required 1", name);
        end else begin
            it = sb.pop_front();
            check(it.name, {q, busy, done, tc}, it.v);
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_val = 4'd0; start = 1'b0; en = 1'b0; auto_reload = 1'b0;

        // One-shot count of 3, restart from DONE, abort by load
        add(1, 4'd3, 1, 1, E(4'd3, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd2, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd1, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd0, 0, 1, 1));
        add(0, 4'd0, 0, 1, E(4'd0, 0, 1, 0));
        add(0, 4'd0, 0, 1, E(4'd0, 0, 1, 0));
        add(0, 4'd0, 1, 1, E(4'd3, 1, 0, 0));
        add(1, 4'd4, 0, 1, E(4'd4, 0, 0, 0));
        // Pause
        add(0, 4'd0, 1, 1, E(4'd4, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd3, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd2, 1, 0, 0));
        add(0, 4'd0, 0, 0, E(4'd2, 1, 0, 0));
        add(0, 4'd0, 0, 0, E(4'd2, 1, 0, 0));
        add(0, 4'd0, 0, 0, E(4'd2, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd1, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd0, 0, 1, 1));
        // Zero reload and precedence
        add(1, 4'd0, 1, 1, E(4'd0, 0, 0, 0));
        add(0, 4'd0, 1, 1, E(4'd0, 0, 1, 0));
        add(1, 4'd6, 1, 1, E(4'd6, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd5, 1, 0, 0));
        add(0, 4'd0, 0, 1, E(4'd4, 1, 0, 0));
        add(1, 4'd9, 0, 1, E(4'd9, 0, 0, 0));
        add(0, 4'd0, 1, 1, E(4'd9, 1, 0, 0));
        add(0, 4'd0, 1, 1, E(4'd8, 1, 0, 0));
        add(1, 4'd0, 0, 1, E(4'd0, 0, 0, 0));
        add(0, 4'd0, 1, 1, E(4'd0, 0, 1, 0));
        add(0, 4'd0, 1, 1, E(4'd0, 0, 1, 0));

        #3;
        check("reset_values", {q, busy, done, tc}, E(4'd0, 0, 0, 0));
        @(posedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            drive($sformatf("vec%0d", i), vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].e, 1'b0, vecs[i].ex);

        // Full range: 15 enabled edges to terminal count, no underflow
        drive("full_load", 1, 4'd15, 1, 1, 0, E(4'd15, 1, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            if (k < 15)       drive($sformatf("full_k%0d", k), 0, 4'd0, 0, 1, 0, E(4'(15 - k), 1, 0, 0));
            else if (k == 15) drive("full_tc", 0, 4'd0, 0, 1, 0, E(4'd0, 0, 1, 1));
            else              drive("full_hold", 0, 4'd0, 0, 1, 0, E(4'd0, 0, 1, 0));
        end

        // Periodic request with reload 2
        drive("per_load", 1, 4'd2, 1, 1, 1, E(4'd2, 1, 0, 0));
        for (int k = 1; k <= 6; k++) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            drive($sformatf("per_k%0d", k), 0, 4'd0, 0, 1, 1,
                  E((k % 2 == 1) ? 4'd1 : 4'd2, 1, 0, (k % 2 == 0)));
`else
            drive($sformatf("per_k%0d", k), 0, 4'd0, 0, 1, 1,
                  (k == 1) ? E(4'd1, 1, 0, 0) : E(4'd0, 0, 1, (k == 2)));
`endif
        end

        // Asynchronous reset mid-count
        drive("rst_load", 1, 4'd5, 1, 1, 0, E(4'd5, 1, 0, 0));
        drive("rst_e1", 0, 4'd0, 0, 1, 0, E(4'd4, 1, 0, 0));
        drive("rst_e2", 0, 4'd0, 0, 1, 0, E(4'd3, 1, 0, 0));
        @(posedge clk);
        reset = 1'b0;
        #1;
        check("reset_async", {q, busy, done, tc}, E(4'd0, 0, 0, 0));
        @(negedge clk);
        #1;
        check("reset_held", {q, busy, done, tc}, E(4'd0, 0, 0, 0));
        @(posedge clk);
        reset = 1'b1;
        // First edge after release is functional; reload register was cleared
        drive("rel_start", 0, 4'd0, 1, 1, 0, E(4'd0, 0, 1, 0));
        drive("rel_load", 1, 4'd2, 1, 1, 0, E(4'd2, 1, 0, 0));
        drive("rel_c1", 0, 4'd0, 0, 1, 0, E(4'd1, 1, 0, 0));
        drive("rel_c2", 0, 4'd0, 0, 1, 0, E(4'd0, 0, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter.md
# down_counter

Synchronous loadable down-counter/timer: the counting-down partner of the team's ripple up-counter. It holds a programmable reload value, counts down to zero on enabled clock edges, and flags terminal count. It can stop at zero (one-shot) or reload and continue (periodic). It sits beside the up-counter in the timing/counter library and serves as the delay and timeout source for control blocks.

## Interface
- `WIDTH`, default 4: counter and reload width in bits.
- `clk`  in  1  clock; all state updates on the falling edge, matching the library flip-flops.
- `reset`  in  1  asynchronous, active-low reset. Low clears all state immediately.
- `load`  in  1  synchronous; latch `load_val` into the reload register and into `q`.
- `load_val`  in  WIDTH  value captured by `load`.
- `start`  in  1  synchronous; begin counting.
- `en`  in  1  count enable; low pauses the count without losing the value.
- `auto_reload`  in  1  1 = periodic mode, 0 = one-shot mode.
- `q`  out  WIDTH  current count.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `tc`  out  1  registered terminal-count pulse, one clock period wide.

## Operation
- **Reset values:** `q`=0, reload register=0, state IDLE, `busy`=0, `done`=0, `tc`=0.
- **States:** IDLE, RUN, DONE. `busy` = (state==RUN). `done` = (state==DONE).
- **Priority on each edge:** `load` > `start` > count.
- **load:**
  - Reload register and `q` take `load_val`.
  - Next state is RUN if `start` is also high and `load_val`≠0. Otherwise it is IDLE.
  - This applies in any state, including mid-RUN (abort and reload).
- **start:**
  - From IDLE: if `q`≠0, go to RUN. If `q`==0, go to DONE; `tc` is not pulsed.
  - From DONE: `q` takes the reload register value. Go to RUN if that value is ≠0, else stay in DONE.
  - From RUN: ignored.
- **RUN with `en`=1:**
  - `q`>1: `q`←`q`−1.
  - `q`==1, one-shot (or periodic with reload register 0): `q`←0, go to DONE, `tc`=1.
  - `q`==1, periodic with reload register ≠0: `q`←reload register, stay in RUN, `tc`=1. The 0 state is never visible.
- **RUN with `en`=0:** `q` and state hold. `tc`=0.
- **DONE:** `q` holds 0 until `load` or `start`.
- **Width rules:**
  - Arithmetic is unsigned modulo 2^WIDTH.
  - `q` never wraps below 0: the q==1 rule intercepts before underflow.
  - `load_val` = all-ones is legal and counts 2^WIDTH−1 periods.
- **Changing `auto_reload` mid-RUN:** it takes effect at the next terminal edge.

## Timing
- `start` sampled at edge N: `busy`=1 after edge N. The first decrement happens at edge N+1 if `en`=1.
- Count length: with reload value V and `en` held high, `tc` asserts after edge N+V and deasserts after edge N+V+1.
- Periodic mode: `tc` pulses every V enabled edges.
- `tc` is registered, never combinational from inputs.
- `done`/`busy` change after the same edge as the state change.
- Reset assertion mid-RUN: all outputs go to reset values asynchronously, without waiting for a clock edge.
- Reset release: the first edge with `reset` high is a normal functional edge.

## Configuration
- Macro: `DOWN_COUNTER_AUTO_RELOAD_EN`.
- **Defined:** periodic mode operates as described.
- **Undefined:**
  - `auto_reload` is ignored and treated as 0; the port remains present.
  - The terminal edge always goes to DONE.
  - The reload register is still used by `start` from DONE.

## Test plan
- **Reset mid-count:** `load_val`=5, `load`+`start`, assert `reset` low after 2 edges → `q`=0, `busy`=0, `done`=0, `tc`=0 immediately, with no edge needed.
- **One-shot count:** WIDTH=4, `load_val`=3, `load`+`start` at edge 0, `en`=1.
  - `q` = 3, 2, 1, 0 after edges 0–3.
  - `tc`=1 only after edge 3; `done`=1 from edge 3.
  - `start` at edge 6 → `q`=3, RUN.
- **Pause:** `load_val`=4, run 2 edges (`q`=2), `en`=0 for 3 edges → `q` stays 2, `busy`=1. Re-enable → `tc` after 2 more edges.
- **Periodic (macro defined):** `load_val`=2, `auto_reload`=1.
  - `q` sequence 2, 1, 2, 1, …
  - `tc` on every second edge; `done` never asserts.
  - With the macro undefined: `done` after the first terminal edge.
- **Zero and precedence:**
  - `load_val`=0 with `load`+`start` → IDLE, `q`=0.
  - Then `start` alone → DONE, `tc`=0.
  - `load`(`load_val`=9) in RUN at `q`=4 → `q`=9, IDLE.
- **Full range:** WIDTH=4, `load_val`=15, one-shot → `tc` exactly 15 edges after start; `q` never shows 15→0 underflow.
